// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: 32-entry register file, operand select and a one-entry pipeline slot.
// Optional macro WB_BYPASS_EN forwards same-cycle write-back data into a capture.
module id_ex_operand_stage #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] rs_addr,
   input  logic [ADDR_WIDTH-1:0] rt_addr,
   input  logic [15:0]           immediate,
   input  logic                  use_immediate,
   input  logic                  sign_extend,
   input  logic [2:0]            alu_control_in,
   input  logic [ADDR_WIDTH-1:0] dest_addr_in,
   input  logic                  reg_write_in,
   input  logic                  flush,
   input  logic                  wb_write_enable,
   input  logic [ADDR_WIDTH-1:0] wb_addr,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] read_data_1,
   output logic [DATA_WIDTH-1:0] read_data_2_or_immediate,
   output logic [2:0]            ALU_control,
   output logic [DATA_WIDTH-1:0] store_data,
   output logic [ADDR_WIDTH-1:0] dest_addr_out,
   output logic                  reg_write_out,
   output logic                  illegal_op
);

   localparam int unsigned NUM_REGS  = 1 << ADDR_WIDTH;
   localparam int unsigned IMM_WIDTH = 16;
   localparam int unsigned EXT_WIDTH = DATA_WIDTH - IMM_WIDTH;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic                  wb_active;
   logic                  capture;
   logic [DATA_WIDTH-1:0] rs_value;
   logic [DATA_WIDTH-1:0] rt_value;
   logic [DATA_WIDTH-1:0] imm_ext;
   logic                  is_illegal;

   assign wb_active = wb_write_enable && (wb_addr != '0);
   assign in_ready  = !reset && (!out_valid || out_ready);
   assign capture   = in_valid && in_ready && !flush;

   // Source reads; register 0 is hard-wired to zero.
   always_comb begin
      rs_value = (rs_addr == '0) ? '0 : regs[rs_addr];
      rt_value = (rt_addr == '0) ? '0 : regs[rt_addr];
`ifdef WB_BYPASS_EN
      if (wb_active && (wb_addr == rs_addr)) rs_value = wb_data;
      if (wb_active && (wb_addr == rt_addr)) rt_value = wb_data;
`endif
   end

   assign imm_ext = sign_extend ? {{EXT_WIDTH{immediate[IMM_WIDTH-1]}}, immediate}
                                : {{EXT_WIDTH{1'b0}}, immediate};

   assign is_illegal = (alu_control_in == 3'd3) || (alu_control_in == 3'd4) ||
                       (alu_control_in == 3'd5);

   // Register file write port; updates regardless of slot stall or flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= '0;
      end else if (wb_active) begin
         regs[wb_addr] <= wb_data;
      end
   end

   // ID/EX slot; data fields only move on capture so a stalled entry stays bit-stable.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid                <= 1'b0;
         read_data_1              <= '0;
         read_data_2_or_immediate <= '0;
         ALU_control              <= '0;
         store_data               <= '0;
         dest_addr_out            <= '0;
         reg_write_out            <= 1'b0;
         illegal_op               <= 1'b0;
      end else begin
         if (flush)          out_valid <= 1'b0;
         else if (capture)   out_valid <= 1'b1;
         else if (out_ready) out_valid <= 1'b0;

         if (capture) begin
            read_data_1              <= rs_value;
            read_data_2_or_immediate <= use_immediate ? imm_ext : rt_value;
            ALU_control              <= alu_control_in;
            store_data               <= rt_value;
            dest_addr_out            <= dest_addr_in;
            reg_write_out            <= reg_write_in;
            illegal_op               <= is_illegal;
         end
      end
   end

endmodule
